// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the chunked carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } cla_state_e;

  function automatic int unsigned nchunk(int unsigned width, int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla.sv
// Combinational BITWIDTH-bit carry-lookahead adder built from prefix generate/propagate terms.
module cla #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  input  logic                carry_in,
  output logic [BITWIDTH-1:0] sum,
  output logic                carry_out,
  output logic                block_propagate,
  output logic                block_generate
);

  logic [BITWIDTH-1:0] p;
  logic [BITWIDTH-1:0] g;
  logic [BITWIDTH-1:0] grp_g;
  logic [BITWIDTH-1:0] grp_p;
  logic [BITWIDTH-1:0] carry;

  assign p = a ^ b;
  assign g = a & b;

  // grp_g/grp_p[i] cover bits i..0, so every carry comes straight from carry_in.
  always_comb begin
    grp_g    = '0;
    grp_p    = '0;
    carry    = '0;
    grp_g[0] = g[0];
    grp_p[0] = p[0];
    carry[0] = carry_in;
    for (int i = 1; i < BITWIDTH; i++) begin
      grp_g[i] = g[i] | (p[i] & grp_g[i-1]);
      grp_p[i] = p[i] & grp_p[i-1];
      carry[i] = grp_g[i-1] | (grp_p[i-1] & carry_in);
    end
  end

  assign sum             = p ^ carry;
  assign carry_out       = grp_g[BITWIDTH-1] | (grp_p[BITWIDTH-1] & carry_in);
  assign block_propagate = grp_p[BITWIDTH-1];
  assign block_generate  = grp_g[BITWIDTH-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Wide adder that streams operands through one CHUNK-bit cla, LSB chunk first,
// with the carry registered between chunks and a valid/ready handshake on each side.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             busy
);

  localparam int unsigned NChunk = nchunk(WIDTH, CHUNK);
  localparam int unsigned IdxW   = idx_width(NChunk);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NChunk - 1);

  cla_state_e state_q, state_d;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic             ready_en_q;
  logic             accept;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic             chunk_cout;
  logic             cla_bp_unused;
  logic             cla_bg_unused;

  assign chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];

  cla #(
    .BITWIDTH(CHUNK)
  ) u_cla (
    .a              (chunk_a),
    .b              (chunk_b),
    .carry_in       (carry_q),
    .sum            (chunk_sum),
    .carry_out      (chunk_cout),
    .block_propagate(cla_bp_unused),
    .block_generate (cla_bg_unused)
  );

  // ready_en_q keeps in_ready low for one cycle after reset is released.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: in_ready = ready_en_q;
      StRun: begin
        busy = 1'b1;
        if (idx_q == IdxLast) state_d = StDone;
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready & ready_en_q;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (in_valid && in_ready) state_d = StRun;
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_b;
        carry_q <= in_cin;
        idx_q   <= '0;
        sum_q   <= '0;
      end else if (state_q == StRun) begin
        sum_q[int'(idx_q)*CHUNK +: CHUNK] <= chunk_sum;
        carry_q <= chunk_cout;
        idx_q   <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign out_sum      = sum_q;
  assign out_cout     = carry_q;
  assign out_overflow = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide-operand adder that sits directly in front of the `cla` block. It accepts a WIDTH-bit add request over a valid/ready handshake, then feeds the operands to a single CHUNK-bit `cla` instance one chunk per cycle, least significant chunk first. The carry is registered between chunks. It assembles the full sum, carry-out and signed overflow, and presents them on an output valid/ready handshake. This trades latency for area so that wide adds reuse one narrow lookahead adder.

## Interface
Parameters:
- WIDTH, 32, operand and sum width. Must be an integer multiple of CHUNK.
- CHUNK, 8, width of the `cla` instance and of the per-cycle slice.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in for chunk 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1.
- out_overflow  out  1  two's-complement overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- NCHUNK = WIDTH/CHUNK. The chunk index counter runs 0..NCHUNK-1.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- IDLE→RUN on in_valid & in_ready. On that edge the block latches in_a, in_b, sets the carry register to in_cin, sets idx=0 and clears the sum register.
- RUN, every cycle:
  - The chunk adder receives a[idx*CHUNK +: CHUNK], b[same slice] and the carry register.
  - Its sum goes into the same slice of the sum register, and its carry_out goes into the carry register. idx increments.
  - When idx==NCHUNK-1, the transition is to DONE.
- Chunk arithmetic requirement: sum slice = a^b^c per bit; carry as normal ripple/lookahead. The result must equal the behavioural model bit-exactly.
- out_overflow = (a[WIDTH-1]==b[WIDTH-1]) & (sum[WIDTH-1]!=a[WIDTH-1]). It is computed from the latched operands.
- DONE behaviour:
  - out_ready=0: all outputs hold stable.
  - out_ready=1 and in_valid=0: → IDLE.
  - out_ready=1 and in_valid=1: the new request is accepted on the same edge and the state goes → RUN (back-to-back).
- NCHUNK=1 is legal: RUN lasts one cycle.
- in_a/in_b/in_cin are ignored outside an accepting edge.

## Timing
- Reset values, held while rst=1: state IDLE, in_ready=0, out_valid=0, out_sum=0, out_cout=0, out_overflow=0, busy=0, idx=0, carry=0. in_ready rises the first cycle after rst deasserts.
- Latency: with acceptance edge E0, out_valid is high after edge E0+NCHUNK. That is 4 cycles for the defaults.
- Throughput: one add per NCHUNK+1 cycles with out_ready tied high and back-to-back requests.
- out_sum, out_cout and out_overflow are registered. They are valid only when out_valid=1 and are held until the handshake completes.
- Reset mid-RUN or mid-DONE aborts the operation with no output. The pending result is lost and out_valid=0 on the cycle after the reset edge.
- in_ready has no combinational path from in_valid. It may depend combinationally on out_ready in DONE only.

## Structure
- Shared package `cla_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - a function for NCHUNK;
  - the index width, max($clog2(NCHUNK),1).
- One sub-module: `cla` instantiated with BITWIDTH=CHUNK. Its block_propagate and block_generate outputs are left unused.
- Everything else lives in `cla_seq_adder`: FSM, index counter, operand/sum/carry registers and overflow logic.

## Test plan
- a=0x0000_00FF, b=0x0000_0001, cin=0 → sum=0x0000_0100, cout=0, ovf=0. out_valid exactly 4 cycles after accept.
- a=0xFFFF_FFFF, b=0, cin=1 → sum=0x0000_0000, cout=1, ovf=0. The carry ripples through all 4 chunks.
- a=0x7FFF_FFFF, b=0x0000_0001, cin=0 → sum=0x8000_0000, cout=0, ovf=1. Also a=0x8000_0000, b=0x8000_0000 → sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_sum stable, in_ready=0. Then raise out_ready with in_valid=1 on the same cycle → new op accepted, its result valid 4 cycles later.
- Assert rst for 1 cycle while idx=2 → out_valid=0 and in_ready=0 the next cycle, in_ready=1 after that. A fresh add 0x1234_5678+0x1111_1111 then returns 0x2345_6789.
- 2000 random operands with randomized in_valid/out_ready, for WIDTH/CHUNK = 32/8, 16/16 and 24/4 → every result matches the model, none dropped or duplicated.
